// File: rtl/sound_length_if.sv
// Register-file side of the APU length-counter unit: NRx1/NRx4 strobes in,
// channel enable / remaining count / expiry pulse out.
interface sound_length_if #(
  parameter int NCH   = 3,
  parameter int WIDTH = 6
);
  logic                     len_tick;
  logic                     seq_phase;
  logic [NCH-1:0]           load;
  logic [NCH*WIDTH-1:0]     load_data;
  logic [NCH-1:0]           nrx4_wr;
  logic [NCH-1:0]           len_en_val;
  logic [NCH-1:0]           trig_val;
  logic [NCH-1:0]           dac_on;
  logic [NCH-1:0]           enable;
  logic [NCH*(WIDTH+1)-1:0] remaining;
  logic [NCH-1:0]           expire;

  modport master (
    output len_tick, seq_phase, load, load_data, nrx4_wr, len_en_val, trig_val, dac_on,
    input  enable, remaining, expire
  );

  modport slave (
    input  len_tick, seq_phase, load, load_data, nrx4_wr, len_en_val, trig_val, dac_on,
    output enable, remaining, expire
  );
endinterface

// File: rtl/sound_length_unit.sv
// Multi-channel DMG-style length counter: load, tick, NRx4 write and DAC gate
// are evaluated as one ordered combinational chain per channel every cycle.
module sound_length_unit #(
  parameter int NCH   = 3,
  parameter int WIDTH = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  sound_length_if.slave  bus
);

  localparam int CW = WIDTH + 1;
  localparam logic [CW-1:0] CNT_FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CW-1:0] CNT_ONE  = {{WIDTH{1'b0}}, 1'b1};

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] len_en_q, len_en_d;
  logic [NCH-1:0] enable_q, enable_d;
  logic [NCH-1:0] expire_q, expire_d;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]    = cnt_q[i];
      len_en_d[i] = len_en_q[i];
      enable_d[i] = enable_q[i];
      expire_d[i] = 1'b0;

      // a load wins over a same-cycle length tick
      if (bus.load[i]) begin
        cnt_d[i] = CNT_FULL - {1'b0, bus.load_data[i*WIDTH +: WIDTH]};
      end else if (bus.len_tick && len_en_q[i] && (cnt_d[i] != '0)) begin
        cnt_d[i] = cnt_d[i] - CNT_ONE;
        if (cnt_d[i] == '0) begin
          enable_d[i] = 1'b0;
          expire_d[i] = 1'b1;
        end
      end

      if (bus.nrx4_wr[i]) begin
        // enabling length in the non-clocking half of the period costs one step
        if (!len_en_q[i] && bus.len_en_val[i] && bus.seq_phase && (cnt_d[i] != '0)) begin
          cnt_d[i] = cnt_d[i] - CNT_ONE;
          if ((cnt_d[i] == '0) && !bus.trig_val[i]) begin
            enable_d[i] = 1'b0;
            expire_d[i] = 1'b1;
          end
        end
        if (bus.trig_val[i]) begin
          enable_d[i] = 1'b1;
          expire_d[i] = 1'b0;
          if (cnt_d[i] == '0) begin
            cnt_d[i] = (bus.len_en_val[i] && bus.seq_phase) ? (CNT_FULL - CNT_ONE) : CNT_FULL;
          end
        end
        len_en_d[i] = bus.len_en_val[i];
      end

      if (!bus.dac_on[i]) begin
        enable_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      len_en_q <= '0;
      enable_q <= '0;
      expire_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      len_en_q <= len_en_d;
      enable_q <= enable_d;
      expire_q <= expire_d;
    end
  end

  assign bus.enable = enable_q;
  assign bus.expire = expire_q;

  for (genvar g = 0; g < NCH; g++) begin : g_rem
    assign bus.remaining[g*CW +: CW] = cnt_q[g];
  end

endmodule

// File: tb/tb_sound_length_unit.sv
// Bench for sound_length_unit: directed edge cases plus randomized strobes
// checked every cycle against an integer reference model of the length rules.
module tb_sound_length_unit;

  localparam int NCH = 3;
  localparam int W   = 6;
  localparam int CW  = W + 1;
  localparam int FULL = 1 << W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sound_length_if #(.NCH(NCH), .WIDTH(W)) bus ();
  sound_length_if #(.NCH(1), .WIDTH(8))   bus8 ();

  sound_length_unit #(.NCH(NCH), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sound_length_unit #(.NCH(1), .WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt [NCH];
  bit m_len [NCH];
  bit m_en  [NCH];
  bit m_exp [NCH];

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rem(input int ch);
    return int'(bus.remaining[ch*CW +: CW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_len[i] = 0; m_en[i] = 0; m_exp[i] = 0;
    end
  endtask

  // length rules applied in order with plain integers
  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      int c   = m_cnt[i];
      bit old = m_len[i];
      bit en  = m_en[i];
      bit ex  = 0;
      bit lv  = bus.len_en_val[i];
      bit tv  = bus.trig_val[i];
      if (bus.load[i]) c = FULL - int'(bus.load_data[i*W +: W]);
      else if (bus.len_tick && old && c > 0) begin
        c = c - 1;
        if (c == 0) begin en = 0; ex = 1; end
      end
      if (bus.nrx4_wr[i]) begin
        if (!old && lv && bus.seq_phase && c > 0) begin
          c = c - 1;
          if (c == 0 && !tv) begin en = 0; ex = 1; end
        end
        if (tv) begin
          en = 1; ex = 0;
          if (c == 0) c = (lv && bus.seq_phase) ? FULL - 1 : FULL;
        end
        m_len[i] = lv;
      end
      if (!bus.dac_on[i]) en = 0;
      m_cnt[i] = c; m_en[i] = en; m_exp[i] = ex;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NCH; i++) begin
      chk_eq($sformatf("enable[%0d]", i), int'(bus.enable[i]), int'(m_en[i]));
      chk_eq($sformatf("expire[%0d]", i), int'(bus.expire[i]), int'(m_exp[i]));
      chk_eq($sformatf("remaining[%0d]", i), rem(i), m_cnt[i]);
    end
  endtask

  task automatic idle();
    bus.load = '0; bus.nrx4_wr = '0; bus.len_tick = 1'b0;
    bus8.load = '0; bus8.nrx4_wr = '0; bus8.len_tick = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    idle();
  endtask

  task automatic ld(input int ch, input logic [W-1:0] d);
    bus.load[ch] = 1'b1;
    bus.load_data[ch*W +: W] = d;
  endtask

  task automatic wr(input int ch, input bit lv, input bit tv);
    bus.nrx4_wr[ch]    = 1'b1;
    bus.len_en_val[ch] = lv;
    bus.trig_val[ch]   = tv;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk_eq("rst_enable8", int'(bus8.enable), 0);
    chk_eq("rst_remaining8", int'(bus8.remaining), 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.seq_phase = 1'b0; bus.load_data = '0; bus.len_en_val = '0; bus.trig_val = '0;
    bus.dac_on = '1;
    bus8.seq_phase = 1'b0; bus8.load_data = '0; bus8.len_en_val = '0; bus8.trig_val = '0;
    bus8.dac_on = 1'b1;
    model_reset();
    #23;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // basic expiry: 64-60 = 4 steps
    ld(0, 6'd60); cyc();
    wr(0, 1, 1); cyc();
    chk_eq("basic_start", rem(0), 4);
    chk_eq("basic_en", int'(bus.enable[0]), 1);
    for (int k = 1; k <= 4; k++) begin
      bus.len_tick = 1'b1; cyc();
      chk_eq("basic_rem", rem(0), 4 - k);
      chk_eq("basic_exp", int'(bus.expire[0]), (k == 4) ? 1 : 0);
      chk_eq("basic_enable", int'(bus.enable[0]), (k == 4) ? 0 : 1);
    end
    cyc();
    chk_eq("expire_one_cycle", int'(bus.expire[0]), 0);

    // zero reload
    wr(0, 0, 1); cyc();
    chk_eq("zero_reload", rem(0), 64);
    chk_eq("zero_reload_en", int'(bus.enable[0]), 1);
    async_reset();
    bus.seq_phase = 1'b1;
    wr(0, 1, 1); cyc();
    chk_eq("zero_reload_sp", rem(0), 63);

    // extra clock, no trigger
    wr(0, 0, 0); cyc();
    ld(0, 6'd63); cyc();
    wr(0, 1, 0); cyc();
    chk_eq("xclk_rem", rem(0), 0);
    chk_eq("xclk_en", int'(bus.enable[0]), 0);
    chk_eq("xclk_exp", int'(bus.expire[0]), 1);
    // extra clock with trigger
    wr(0, 0, 0); cyc();
    ld(0, 6'd63); cyc();
    wr(0, 1, 1); cyc();
    chk_eq("xclk_trig_rem", rem(0), 63);
    chk_eq("xclk_trig_en", int'(bus.enable[0]), 1);
    chk_eq("xclk_trig_exp", int'(bus.expire[0]), 0);

    // collisions
    ld(0, 6'd10); bus.len_tick = 1'b1; cyc();
    chk_eq("load_tick", rem(0), 54);
    bus.len_tick = 1'b1; wr(0, 0, 0); cyc();
    chk_eq("tick_old_len_en", rem(0), 53);
    bus.len_tick = 1'b1; cyc();
    chk_eq("len_en_off_hold", rem(0), 53);

    // DAC gate
    bus.seq_phase = 1'b0;
    wr(0, 1, 0); cyc();
    bus.dac_on[0] = 1'b0; cyc();
    chk_eq("dac_en", int'(bus.enable[0]), 0);
    chk_eq("dac_exp", int'(bus.expire[0]), 0);
    chk_eq("dac_rem", rem(0), 53);
    ld(0, 6'd63); cyc();
    bus.len_tick = 1'b1; cyc();
    chk_eq("dac_counts_down", rem(0), 0);
    wr(0, 1, 1); cyc();
    chk_eq("dac_trig_en", int'(bus.enable[0]), 0);
    chk_eq("dac_trig_reload", rem(0), 64);
    bus.dac_on[0] = 1'b1;

    // channel 1 only; model confirms 0 and 2 untouched
    ld(1, 6'd20); cyc();
    wr(1, 1, 1); cyc();
    chk_eq("ch1_rem", rem(1), 44);
    async_reset();

    // WIDTH=8 single channel: load 0 gives 256 steps
    bus8.load = 1'b1; bus8.load_data = 8'd0; cyc();
    bus8.nrx4_wr = 1'b1; bus8.len_en_val = 1'b1; bus8.trig_val = 1'b1; cyc();
    chk_eq("w8_start", int'(bus8.remaining), 256);
    for (int k = 1; k <= 256; k++) begin
      bus8.len_tick = 1'b1; cyc();
      chk_eq("w8_exp", int'(bus8.expire), (k == 256) ? 1 : 0);
      chk_eq("w8_rem", int'(bus8.remaining), 256 - k);
    end
    chk_eq("w8_en", int'(bus8.enable), 0);

    // randomized strobes
    for (int n = 0; n < 3000; n++) begin
      if (n % 997 == 500) async_reset();
      if ($urandom_range(7) == 0) bus.seq_phase = ~bus.seq_phase;
      bus.len_tick = ($urandom_range(2) == 0);
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(15) == 0) ld(ch, W'($urandom));
        if ($urandom_range(7) == 0) wr(ch, bit'($urandom_range(1)), bit'($urandom_range(1)));
        if ($urandom_range(39) == 0) bus.dac_on[ch] = ~bus.dac_on[ch];
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
